// File: rtl/rand_char_uart_pkg.sv
// Shared types and constants for the random-character UART generator.
// RAND_CHAR_UART_PARITY_EN adds an even-parity bit (8E1 framing).
package rand_char_uart_pkg;

  localparam logic [7:0]  ASCII_BASE   = 8'h61;
  localparam int          ALPHABET_LEN = 26;
  // Taps at bits 15,13,12,10: x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

`ifdef RAND_CHAR_UART_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } uart_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE, ST_START, ST_DATA, ST_STOP
  } uart_state_e;
`endif

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Fold the 32 possible 5-bit values onto the 26 letters.
  function automatic logic [7:0] ascii_map(input logic [4:0] v);
    logic [4:0] idx;
    idx = (v < 5'(ALPHABET_LEN)) ? v : v - 5'(ALPHABET_LEN);
    return ASCII_BASE + {3'b000, idx};
  endfunction

endpackage

// File: rtl/rand_char_uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even parity
// (RAND_CHAR_UART_PARITY_EN), one stop bit; s_out is registered.
module uart_tx
  import rand_char_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       s_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             so_q, so_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef RAND_CHAR_UART_PARITY_EN
  logic             par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign s_out   = so_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      so_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef RAND_CHAR_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      so_q    <= so_d;
      done_q  <= done_d;
`ifdef RAND_CHAR_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // so_d is the level for the state being entered, so s_out changes on the
  // same edge as the state and each bit lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    so_d    = so_q;
    done_d  = 1'b0;
`ifdef RAND_CHAR_UART_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != ST_IDLE)
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        so_d = 1'b1;
        if (start) begin
          state_d = ST_START;
          sh_d    = data;
          cnt_d   = '0;
          so_d    = 1'b0;
`ifdef RAND_CHAR_UART_PARITY_EN
          par_d   = ^data;
`endif
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          so_d    = sh_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef RAND_CHAR_UART_PARITY_EN
            state_d = ST_PARITY;
            so_d    = par_q;
`else
            state_d = ST_STOP;
            so_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            so_d  = sh_q[1];
          end
        end
      end
`ifdef RAND_CHAR_UART_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          so_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          so_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        so_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rand_char_uart_top.sv
// Random lowercase-letter generator: request edge -> LFSR char -> FIFO -> UART.
// RAND_CHAR_UART_PARITY_EN switches the serial framing from 8N1 to 8E1.
module rand_char_uart_top
  import rand_char_uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic clk,
  input  logic rst,
  input  logic request_char,
  output logic s_out
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic             req_q;
  logic             push_req, push, pop;
  logic [15:0]      lfsr_to_ascii;
  logic [7:0]       ascii_to_fifo;
  logic [7:0]       fifo_out_to_uart;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             uart_busy;
  // Frame-complete strobe; observed hierarchically, the top has no use for it.
  logic             uart_done_unused;

  assign push_req   = request_char & ~req_q;
  assign fifo_full  = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign pop        = ~fifo_empty & ~uart_busy;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push       = push_req & (~fifo_full | pop);

  assign ascii_to_fifo    = ascii_map(lfsr_to_ascii[4:0]);
  assign fifo_out_to_uart = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q         <= 1'b0;
      lfsr_to_ascii <= LFSR_SEED;
    end else begin
      req_q <= request_char;
      if (push)
        lfsr_to_ascii <= lfsr_next(lfsr_to_ascii);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= ascii_to_fifo;
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) UART (
    .clk  (clk),
    .rst  (rst),
    .start(pop),
    .data (fifo_out_to_uart),
    .busy (uart_busy),
    .done (uart_done_unused),
    .s_out(s_out)
  );

endmodule

// File: tb/tb_rand_char_uart_top.sv
// Self-checking bench: decodes s_out frames and compares them against an
// arithmetic LFSR/letter model; covers reset, latency, full FIFO, abort.
module tb_rand_char_uart_top;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
  localparam logic [15:0] SEED  = 16'hACE1;
`ifdef RAND_CHAR_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic request_char = 1'b0;
  logic s_out;

  int checks = 0;
  int errors = 0;

  rand_char_uart_top #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .LFSR_SEED   (SEED)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .request_char(request_char),
    .s_out       (s_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [7:0] m_char(input logic [15:0] s);
    int v;
    v = int'(s[4:0]) % 26;
    return 8'(97 + v);
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    request_char = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    @(negedge clk) request_char = 1'b1;
    @(negedge clk) request_char = 1'b0;
  endtask

  // Wait (bounded) for a start bit, then sample every cycle of the frame.
  task automatic recv_frame(input int timeout, output logic [7:0] b,
                            output bit got, output int waited);
    logic smp [NBITS*CPB];
    bit   dn_early;
    int   bad;
    got = 0; b = '0; waited = 0; dn_early = 0; bad = 0;
    for (int t = 0; t < timeout; t++) begin
      @(negedge clk);
      if (s_out === 1'b0) begin
        got = 1;
        break;
      end
      waited++;
    end
    if (!got) return;
    smp[0] = s_out;
    for (int k = 1; k < NBITS*CPB; k++) begin
      @(negedge clk);
      smp[k] = s_out;
      if (dut.UART.done === 1'b1) dn_early = 1;
    end
    @(negedge clk);
    chk("done_pulse", {31'b0, dut.UART.done}, 32'd1);
    chk("done_early", {31'b0, dn_early}, 32'd0);
    for (int i = 0; i < NBITS; i++)
      for (int j = 1; j < CPB; j++)
        if (smp[i*CPB+j] !== smp[i*CPB]) bad++;
    chk("bit_len", bad, 0);
    chk("start_bit", {31'b0, smp[0]}, 32'd0);
    for (int i = 0; i < 8; i++) b[i] = smp[(i+1)*CPB];
`ifdef RAND_CHAR_UART_PARITY_EN
    chk("parity", {31'b0, smp[9*CPB]}, {31'b0, ^b});
`endif
    chk("stop_bit", {31'b0, smp[(NBITS-1)*CPB]}, 32'd1);
  endtask

  // Drains frames until the line has been idle for a while.
  task automatic run_rx(output int n, output logic [15:0] ms);
    logic [7:0] b;
    bit got;
    int w;
    n = 0;
    ms = SEED;
    for (int f = 0; f < 200; f++) begin
      recv_frame(300, b, got, w);
      if (!got) break;
      chk("stream_char", {24'b0, b}, {24'b0, m_char(ms)});
      ms = m_step(ms);
      n++;
    end
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] ms, lf;
    bit          got, seen;
    int          w, n, maxc;

    // Reset state and quiet line
    do_reset(3);
    chk("rst_lfsr", dut.lfsr_to_ascii, SEED);
    for (int i = 0; i < 10; i++) begin
      repeat (10) @(negedge clk);
      chk("rst_sout", {31'b0, s_out}, 32'd1);
      chk("rst_empty", dut.fifo_count, 0);
    end

    // First and second characters with latency
    pulse_req();
    chk("lfsr1", dut.lfsr_to_ascii, 16'h59C3);
    recv_frame(20, b, got, w);
    chk("frame1_seen", {31'b0, got}, 32'd1);
    chk("latency", w, 0);
    chk("char1", {24'b0, b}, 32'h62);
    pulse_req();
    recv_frame(20, b, got, w);
    chk("char2", {24'b0, b}, {24'b0, m_char(m_step(SEED))});
    chk("char2_d", {24'b0, b}, 32'h64);

    // Reset in the middle of the data bits
    pulse_req();
    seen = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (s_out === 1'b0) begin seen = 1; break; end
    end
    chk("abort_start", {31'b0, seen}, 32'd1);
    repeat (CPB*3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_sout", {31'b0, s_out}, 32'd1);
    chk("abort_fifo", dut.fifo_count, 0);
    chk("abort_lfsr", dut.lfsr_to_ascii, SEED);
    @(negedge clk) rst = 1'b0;
    pulse_req();
    recv_frame(20, b, got, w);
    chk("post_abort", {24'b0, b}, 32'h62);

    // Toggle every clock: fill, drop, then push coinciding with a pop at full
    do_reset(3);
    maxc = 0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          @(negedge clk) request_char = ~request_char;
          if (int'(dut.fifo_count) > maxc) maxc = int'(dut.fifo_count);
        end
        request_char = 1'b0;
        chk("fill_max", maxc, DEPTH);
        chk("full_now", dut.fifo_count, DEPTH);
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          if (dut.UART.done === 1'b1) seen = 1;
        end
        for (int i = 0; i < 20; i++)
          @(negedge clk) request_char = ~request_char;
        request_char = 1'b0;
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          if (dut.UART.done === 1'b1) seen = 1;
        end
        chk("pp_done_seen", {31'b0, seen}, 32'd1);
        chk("pp_full_pre", dut.fifo_count, DEPTH);
        lf = dut.lfsr_to_ascii;
        request_char = 1'b1;
        @(negedge clk);
        chk("pp_count", dut.fifo_count, DEPTH);
        chk("pp_lfsr", dut.lfsr_to_ascii, m_step(lf));
        request_char = 1'b0;
      end
      run_rx(n, ms);
    join
    chk("stream_frames", {31'b0, n > DEPTH + 2}, 32'd1);
    chk("stream_lfsr", dut.lfsr_to_ascii, ms);
    chk("stream_empty", dut.fifo_count, 0);

    // Random request levels
    do_reset(3);
    fork
      for (int i = 0; i < 300; i++)
        @(negedge clk) request_char = 1'($urandom_range(0, 1));
      run_rx(n, ms);
    join
    request_char = 1'b0;
    chk("rand_frames", {31'b0, n > 0}, 32'd1);
    chk("rand_lfsr", dut.lfsr_to_ascii, ms);
    chk("rand_sout", {31'b0, s_out}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
